// File: rtl/decoder_scan_seq.sv
// Scan sequencer for a 3-to-8 decoder: walks the enabled outputs in ascending order,
// holding each for DWELL cycles with an optional E-low blanking gap before each select.
module decoder_scan_seq #(
   parameter int unsigned DWELL     = 4,
   parameter int unsigned BLANK_CYC = 1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic       clka,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       continuous,
   input  logic [7:0] mask,
   output logic       E,
   output logic [2:0] In,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {StIdle, StBlank, StScan} state_e;

   localparam bit               HasBlank  = (BLANK_CYC > 0);
   localparam logic [CNT_W-1:0] DwellLoad = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BlankLoad = HasBlank ? CNT_W'(BLANK_CYC - 1) : '0;
   // Every new select begins in BLANK, or goes straight to SCAN when blanking is disabled.
   localparam state_e           FirstSt   = HasBlank ? StBlank : StScan;
   localparam logic [CNT_W-1:0] FirstLoad = HasBlank ? BlankLoad : DwellLoad;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       mask_q, mask_d;
   logic             cont_q, cont_d;
   logic [2:0]       in_q, in_d;
   logic             e_q, e_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [2:0]       nxt_idx;
   logic             nxt_found;
   logic [2:0]       low_idx;

   // Lowest latched index strictly above the current one.
   always_comb begin
      nxt_idx   = '0;
      nxt_found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(in_q))) begin
            nxt_idx   = 3'(i);
            nxt_found = 1'b1;
         end
      end
   end

   // Lowest set bit of the live mask input, used at every latch point.
   always_comb begin
      low_idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) begin
            low_idx = 3'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      cont_d  = cont_q;
      in_d    = in_q;
      done_d  = 1'b0;

      case (state_q)
         StIdle: begin
            if (start && !stop && (mask != 8'h00)) begin
               mask_d  = mask;
               cont_d  = continuous;
               in_d    = low_idx;
               state_d = FirstSt;
               cnt_d   = FirstLoad;
            end
         end
         StBlank: begin
            if (stop) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = StScan;
               cnt_d   = DwellLoad;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StScan: begin
            if (stop) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (nxt_found) begin
               in_d    = nxt_idx;
               state_d = FirstSt;
               cnt_d   = FirstLoad;
            end else if (cont_q && (mask != 8'h00)) begin
               mask_d  = mask;
               in_d    = low_idx;
               state_d = FirstSt;
               cnt_d   = FirstLoad;
               done_d  = 1'b1;
            end else begin
               state_d = StIdle;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      e_d    = (state_d == StScan);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mask_q  <= '0;
         cont_q  <= 1'b0;
         in_q    <= '0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         cont_q  <= cont_d;
         in_q    <= in_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign E    = e_q;
   assign In   = in_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: three parameterisations checked cycle by cycle against
// expected traces built from the scan rules (blank gap, dwell, done on sweep end/wrap).
module tb_decoder_scan_seq;

   typedef struct packed {
      logic       e;
      logic [2:0] idx;
      logic       busy;
      logic       done;
   } obs_t;

   logic       clka = 1'b0;
   logic       rst_n;
   logic [2:0] start_v, stop_v, cont_v, e_v, busy_v, done_v;
   logic [7:0] mask_v [3];
   logic [2:0] in_v [3];

   int checks   = 0;
   int failures = 0;
   obs_t exp_q[$];

   always #5 clka = ~clka;

   decoder_scan_seq #(.DWELL(2), .BLANK_CYC(1), .CNT_W(8)) u_dut_a (
      .clka(clka), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]),
      .continuous(cont_v[0]), .mask(mask_v[0]), .E(e_v[0]), .In(in_v[0]),
      .busy(busy_v[0]), .done(done_v[0]));

   decoder_scan_seq #(.DWELL(1), .BLANK_CYC(0), .CNT_W(8)) u_dut_b (
      .clka(clka), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]),
      .continuous(cont_v[1]), .mask(mask_v[1]), .E(e_v[1]), .In(in_v[1]),
      .busy(busy_v[1]), .done(done_v[1]));

   decoder_scan_seq #(.DWELL(3), .BLANK_CYC(2), .CNT_W(4)) u_dut_c (
      .clka(clka), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]),
      .continuous(cont_v[2]), .mask(mask_v[2]), .E(e_v[2]), .In(in_v[2]),
      .busy(busy_v[2]), .done(done_v[2]));

   function automatic int dwell_of(input int s);
      case (s)
         0:       return 2;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int blank_of(input int s);
      case (s)
         0:       return 1;
         1:       return 0;
         default: return 2;
      endcase
   endfunction

   task automatic get_obs(input int s, output obs_t o);
      o.e    = e_v[s];
      o.idx  = in_v[s];
      o.busy = busy_v[s];
      o.done = done_v[s];
   endtask

   // One sweep: for each enabled index, blank cycles (E low) then dwell cycles (E high).
   task automatic add_sweep(input int s, input logic [7:0] m, input logic wrap_done);
      obs_t o;
      bit   first;
      first = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            for (int b = 0; b < blank_of(s); b++) begin
               o.e = 1'b0; o.idx = 3'(i); o.busy = 1'b1; o.done = first & wrap_done;
               exp_q.push_back(o);
               first = 1'b0;
            end
            for (int d = 0; d < dwell_of(s); d++) begin
               o.e = 1'b1; o.idx = 3'(i); o.busy = 1'b1; o.done = first & wrap_done;
               exp_q.push_back(o);
               first = 1'b0;
            end
         end
      end
   endtask

   task automatic add_idle(input logic [2:0] idx, input logic dn);
      obs_t o;
      o.e = 1'b0; o.idx = idx; o.busy = 1'b0; o.done = dn;
      exp_q.push_back(o);
   endtask

   task automatic test_reset();
      obs_t o;
      rst_n = 1'b0;
      repeat (2) @(negedge clka);
      for (int s = 0; s < 3; s++) begin
         get_obs(s, o);
         checks++;
         if (o !== 6'b0) begin
            failures++;
            $display("FAIL reset_init dut%0d: got {e,in,busy,done}=%b expected %b", s, o, 6'b0);
         end
      end
      rst_n = 1'b1;
      @(negedge clka);
      mask_v[0] = 8'h05; cont_v[0] = 1'b0; start_v[0] = 1'b1;
      @(negedge clka);
      start_v[0] = 1'b0;
      repeat (2) @(negedge clka);
      get_obs(0, o);
      checks++;
      if (!(o.e && o.busy)) begin
         failures++;
         $display("FAIL reset_prescan: got {e,in,busy,done}=%b expected e=1 busy=1", o);
      end
      #2 rst_n = 1'b0;
      #1 get_obs(0, o);
      checks++;
      if (o !== 6'b0) begin
         failures++;
         $display("FAIL reset_async: got {e,in,busy,done}=%b expected %b", o, 6'b0);
      end
      @(negedge clka);
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clka);
         get_obs(0, o);
         checks++;
         if (o !== 6'b0) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: got %b expected %b", j, o, 6'b0);
         end
      end
   endtask

   task automatic test_stop_and_start_edges();
      obs_t o;
      exp_q.delete();
      o = {1'b0, 3'd0, 1'b1, 1'b0}; exp_q.push_back(o);
      o = {1'b1, 3'd0, 1'b1, 1'b0}; exp_q.push_back(o);
      o = {1'b1, 3'd0, 1'b1, 1'b0}; exp_q.push_back(o);
      add_idle(3'd0, 1'b0);
      add_idle(3'd0, 1'b0);
      mask_v[0] = 8'h05; cont_v[0] = 1'b0; start_v[0] = 1'b1;
      for (int j = 0; j < exp_q.size(); j++) begin
         @(negedge clka);
         if (j == 0) start_v[0] = 1'b0;
         if (j == 3) stop_v[0] = 1'b0;
         get_obs(0, o);
         checks++;
         if (o !== exp_q[j]) begin
            failures++;
            $display("FAIL stop_mid_scan cycle %0d: got %b expected %b", j, o, exp_q[j]);
         end
         if (j == 2) stop_v[0] = 1'b1;
      end
      mask_v[0] = 8'hFF; start_v[0] = 1'b1; stop_v[0] = 1'b1;
      for (int j = 0; j < 2; j++) begin
         @(negedge clka);
         get_obs(0, o);
         checks++;
         if (o !== 6'b0) begin
            failures++;
            $display("FAIL start_stop_same cycle %0d: got %b expected %b", j, o, 6'b0);
         end
      end
      stop_v[0] = 1'b0; mask_v[0] = 8'h00;
      for (int j = 0; j < 2; j++) begin
         @(negedge clka);
         get_obs(0, o);
         checks++;
         if (o !== 6'b0) begin
            failures++;
            $display("FAIL start_mask_zero cycle %0d: got %b expected %b", j, o, 6'b0);
         end
      end
      start_v[0] = 1'b0;
   endtask

   task automatic test_single_sweep();
      obs_t o;
      exp_q.delete();
      add_sweep(0, 8'h05, 1'b0);
      add_idle(3'd2, 1'b1);
      add_idle(3'd2, 1'b0);
      mask_v[0] = 8'h05; cont_v[0] = 1'b0; start_v[0] = 1'b1;
      for (int j = 0; j < exp_q.size(); j++) begin
         @(negedge clka);
         if (j == 0) start_v[0] = 1'b0;
         get_obs(0, o);
         checks++;
         if (o !== exp_q[j]) begin
            failures++;
            $display("FAIL single_sweep cycle %0d: got %b expected %b", j, o, exp_q[j]);
         end
      end
   endtask

   task automatic test_mask_change();
      obs_t o;
      exp_q.delete();
      add_sweep(0, 8'h81, 1'b0);
      add_sweep(0, 8'h10, 1'b1);
      add_idle(3'd4, 1'b1);
      add_idle(3'd4, 1'b0);
      mask_v[0] = 8'h81; cont_v[0] = 1'b1; start_v[0] = 1'b1;
      for (int j = 0; j < exp_q.size(); j++) begin
         @(negedge clka);
         if (j == 0) start_v[0] = 1'b0;
         if (j == 1) begin
            mask_v[0] = 8'h10;
            cont_v[0] = 1'b0;
         end
         if (j == 6) mask_v[0] = 8'h00;
         get_obs(0, o);
         checks++;
         if (o !== exp_q[j]) begin
            failures++;
            $display("FAIL mask_change cycle %0d: got %b expected %b", j, o, exp_q[j]);
         end
      end
   endtask

   task automatic test_continuous_full();
      obs_t o;
      exp_q.delete();
      add_sweep(1, 8'hFF, 1'b0);
      add_sweep(1, 8'hFF, 1'b1);
      add_sweep(1, 8'hFF, 1'b1);
      add_idle(3'd7, 1'b0);
      mask_v[1] = 8'hFF; cont_v[1] = 1'b1; start_v[1] = 1'b1;
      for (int j = 0; j < exp_q.size(); j++) begin
         @(negedge clka);
         if (j == 0) begin
            start_v[1] = 1'b0;
            cont_v[1]  = 1'b0;
         end
         if (j == 24) stop_v[1] = 1'b0;
         get_obs(1, o);
         checks++;
         if (o !== exp_q[j]) begin
            failures++;
            $display("FAIL continuous cycle %0d: got %b expected %b", j, o, exp_q[j]);
         end
         if (j == 23) stop_v[1] = 1'b1;
      end
   endtask

   task automatic test_random_sweeps();
      obs_t       o;
      int         s;
      logic [7:0] m;
      logic [2:0] last;
      for (int it = 0; it < 24; it++) begin
         s = $urandom_range(0, 2);
         m = 8'($urandom_range(0, 255));
         if (it % 6 == 5) m = 8'h00;
         exp_q.delete();
         last = '0;
         for (int i = 0; i < 8; i++) if (m[i]) last = 3'(i);
         @(negedge clka);
         mask_v[s] = m; cont_v[s] = 1'b0; start_v[s] = 1'b1;
         if (m == 8'h00) begin
            @(negedge clka);
            start_v[s] = 1'b0;
            get_obs(s, o);
            checks++;
            if ({o.e, o.busy, o.done} !== 3'b000) begin
               failures++;
               $display("FAIL random_mask_zero it %0d dut%0d: got %b expected e/busy/done=0",
                        it, s, o);
            end
         end else begin
            add_sweep(s, m, 1'b0);
            add_idle(last, 1'b1);
            add_idle(last, 1'b0);
            for (int j = 0; j < exp_q.size(); j++) begin
               @(negedge clka);
               if (j == 0) start_v[s] = 1'b0;
               get_obs(s, o);
               checks++;
               if (o !== exp_q[j]) begin
                  failures++;
                  $display("FAIL random_sweep it %0d dut%0d mask %h cycle %0d: got %b expected %b",
                           it, s, m, j, o, exp_q[j]);
               end
               // Mid-sweep input churn must not disturb the latched mask or mode.
               mask_v[s] = 8'($urandom_range(0, 255));
               cont_v[s] = 1'($urandom_range(0, 1));
            end
            cont_v[s] = 1'b0;
         end
      end
   endtask

   initial begin
      start_v = '0; stop_v = '0; cont_v = '0;
      for (int s = 0; s < 3; s++) mask_v[s] = 8'h00;
      test_reset();
      test_stop_and_start_edges();
      test_single_sweep();
      test_mask_change();
      test_continuous_full();
      test_random_sweeps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
